sdram_init_seq: RTL

//  Runs the SDR SDRAM power-up initialisation in the 100 MHz domain, downstream of the PLL.

---
 rtl/sdram_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/sdram_init_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - SDRAM command encodings and init sequencer state encoding
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LMR       = 4'b0000;

  typedef logic [3:0] state_t;

  localparam state_t ST_WAIT_LOCK = 4'd0;
  localparam state_t ST_POWERUP   = 4'd1;
  localparam state_t ST_PRECHARGE = 4'd2;
  localparam state_t ST_WAIT_RP   = 4'd3;
  localparam state_t ST_REFRESH   = 4'd4;
  localparam state_t ST_WAIT_RFC  = 4'd5;
  localparam state_t ST_LOAD_MODE = 4'd6;
  localparam state_t ST_WAIT_MRD  = 4'd7;
  localparam state_t ST_DONE      = 4'd8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchroniser, resets to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is safe to use in the clk domain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdram_init_seq.sv
// rtl/sdram_init_seq.sv - SDR SDRAM power-up init sequencer (option: SDRAM_INIT_RELOCK_EN)
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int T_POWERUP = 20000,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 7,
  parameter int T_MRD     = 2,
  parameter int N_REFRESH = 8,
  parameter int ROW_W     = 13,
  parameter int BA_W      = 2,
  parameter logic [ROW_W-1:0] MODE_REG = 13'h030
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  output logic             cke,
  output logic [3:0]       cmd,
  output logic [ROW_W-1:0] addr,
  output logic [BA_W-1:0]  ba,
  output logic             init_done
);

  localparam int WAIT_W = $clog2(T_POWERUP + 1);
  localparam int REF_W  = $clog2(N_REFRESH + 1);

  // PRECHARGE ALL is selected by A10 high
  localparam logic [ROW_W-1:0] PRE_ADDR = ROW_W'(11'h400);

  state_t              state;
  state_t              next_state;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_load;
  logic [REF_W-1:0]    ref_cnt;
  logic                wait_done;
  logic                locked_s;
  logic                lock_lost;

  logic                cke_d;
  logic [3:0]          cmd_d;
  logic [ROW_W-1:0]    addr_d;
  logic                init_done_d;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  assign wait_done = (wait_cnt == '0);

`ifdef SDRAM_INIT_RELOCK_EN
  assign lock_lost = !locked_s && (state != ST_WAIT_LOCK);
`else
  assign lock_lost = !locked_s && (state != ST_WAIT_LOCK) && (state != ST_DONE);
`endif

  // Next-state decode; lock loss overrides every sequencing decision
  always_comb begin
    next_state = state;
    case (state)
      ST_WAIT_LOCK: if (locked_s) next_state = ST_POWERUP;
      ST_POWERUP:   if (wait_done) next_state = ST_PRECHARGE;
      ST_PRECHARGE: next_state = ST_WAIT_RP;
      ST_WAIT_RP:   if (wait_done) next_state = ST_REFRESH;
      ST_REFRESH:   next_state = ST_WAIT_RFC;
      ST_WAIT_RFC: begin
        if (wait_done) begin
          next_state = (ref_cnt == REF_W'(N_REFRESH)) ? ST_LOAD_MODE : ST_REFRESH;
        end
      end
      ST_LOAD_MODE: next_state = ST_WAIT_MRD;
      ST_WAIT_MRD:  if (wait_done) next_state = ST_DONE;
      ST_DONE:      next_state = ST_DONE;
      default:      next_state = ST_WAIT_LOCK;
    endcase
    if (lock_lost) next_state = ST_WAIT_LOCK;
  end

  // Wait length loaded on entry; the one-cycle command state already counts
  // toward each command-to-command spacing, hence the -2 on the wait states
  always_comb begin
    wait_load = '0;
    case (next_state)
      ST_POWERUP:  wait_load = WAIT_W'(T_POWERUP - 1);
      ST_WAIT_RP:  wait_load = WAIT_W'(T_RP - 2);
      ST_WAIT_RFC: wait_load = WAIT_W'(T_RFC - 2);
      ST_WAIT_MRD: wait_load = WAIT_W'(T_MRD - 2);
      default:     wait_load = '0;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with state
  always_comb begin
    cke_d       = 1'b1;
    cmd_d       = CMD_NOP;
    addr_d      = '0;
    init_done_d = 1'b0;
    case (next_state)
      ST_WAIT_LOCK: begin
        cke_d = 1'b0;
        cmd_d = CMD_INHIBIT;
      end
      ST_PRECHARGE: begin
        cmd_d  = CMD_PRECHARGE;
        addr_d = PRE_ADDR;
      end
      ST_REFRESH: cmd_d = CMD_REFRESH;
      ST_LOAD_MODE: begin
        cmd_d  = CMD_LMR;
        addr_d = MODE_REG;
      end
      ST_DONE: init_done_d = 1'b1;
      default: ;
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_WAIT_LOCK;
      wait_cnt  <= '0;
      ref_cnt   <= '0;
      cke       <= 1'b0;
      cmd       <= CMD_INHIBIT;
      addr      <= '0;
      ba        <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= next_state;
      cke       <= cke_d;
      cmd       <= cmd_d;
      addr      <= addr_d;
      ba        <= '0;
      init_done <= init_done_d;
      if (next_state == ST_WAIT_LOCK) begin
        wait_cnt <= '0;
        ref_cnt  <= '0;
      end else begin
        if (next_state != state) begin
          wait_cnt <= wait_load;
        end else if (!wait_done) begin
          wait_cnt <= wait_cnt - 1'b1;
        end
        if (next_state == ST_REFRESH && state != ST_REFRESH &&
            ref_cnt != REF_W'(N_REFRESH)) begin
          ref_cnt <= ref_cnt + 1'b1;
        end
      end
    end
  end

endmodule
